// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit: result record, source indices
// and a one-hot helper used by the pending-destination bitmaps.
package wb_pkg;
  localparam int unsigned WB_DATA_WIDTH    = 8;
  localparam int unsigned WB_VECTOR_SIZE   = 6;
  localparam int unsigned WB_REGNUM        = 16;
  localparam int unsigned WB_ADDRESS_WIDTH = $clog2(WB_REGNUM);

  localparam logic SRC_EX  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic                                            isVector;
    logic [WB_ADDRESS_WIDTH-1:0]                     address;
    logic [WB_DATA_WIDTH-1:0]                        scalarData;
    logic [WB_VECTOR_SIZE-1:0][WB_DATA_WIDTH-1:0]    vectorData;
  } wb_result_t;

  function automatic logic [WB_REGNUM-1:0] wb_onehot(input logic en,
                                                     input logic [WB_ADDRESS_WIDTH-1:0] addr);
    wb_onehot       = '0;
    wb_onehot[addr] = en;
  endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// Valid/ready result channel from one pipeline source into a writeback holder.
interface writeback_unit_if;
  import wb_pkg::*;

  logic       valid;
  logic       ready;
  wb_result_t result;

  modport master (output valid, output result, input ready);
  modport slave  (input valid, input result, output ready);
endinterface

// File: rtl/wb_holder.sv
// One-entry result buffer. Ready while empty or while being drained this cycle,
// so a granted holder can refill on the same edge.
module wb_holder
  import wb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  writeback_unit_if.slave         src,
  input  logic                    clear,
  output logic                    full,
  output wb_result_t              entry
);
  logic       full_q, full_d;
  wb_result_t entry_q, entry_d;
  logic       load;

  always_comb begin
    src.ready = !full_q || clear;
    load      = src.valid && src.ready;
    full_d    = full_q;
    entry_d   = entry_q;
    if (load) begin
      full_d  = 1'b1;
      entry_d = src.result;
    end else if (clear) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full  = full_q;
  assign entry = entry_q;
endmodule

// File: rtl/writeback_unit.sv
// Register-file write side: buffers one execute and one memory result, issues the older
// one per cycle onto the shared write port. Optional counters under WB_PERF_COUNTERS_EN.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int unsigned VECTOR_SIZE   = WB_VECTOR_SIZE,
  parameter int unsigned REGNUM        = WB_REGNUM,
  parameter int unsigned ADDRESS_WIDTH = $clog2(REGNUM)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              exValid,
  output logic                              exReady,
  input  logic                              exIsVector,
  input  logic [ADDRESS_WIDTH-1:0]          exAddress,
  input  logic [DATA_WIDTH-1:0]             exScalarData,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] exVectorData,
  input  logic                              memValid,
  output logic                              memReady,
  input  logic                              memIsVector,
  input  logic [ADDRESS_WIDTH-1:0]          memAddress,
  input  logic [DATA_WIDTH-1:0]             memScalarData,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] memVectorData,
  output logic                              writeEnableScalar,
  output logic                              writeEnableVector,
  output logic [ADDRESS_WIDTH-1:0]          writeAddress,
  output logic [DATA_WIDTH-1:0]             writeScalarData,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] writeVectorData,
  output logic [REGNUM-1:0]                 pendingScalar,
  output logic [REGNUM-1:0]                 pendingVector
`ifdef WB_PERF_COUNTERS_EN
  ,
  output logic [31:0]                       scalarWriteCount,
  output logic [31:0]                       vectorWriteCount,
  output logic [31:0]                       stallCount
`endif
);
  writeback_unit_if ex_bus ();
  writeback_unit_if mem_bus ();

  assign ex_bus.valid   = exValid;
  assign ex_bus.result  = '{isVector: exIsVector, address: exAddress,
                            scalarData: exScalarData, vectorData: exVectorData};
  assign exReady        = ex_bus.ready;
  assign mem_bus.valid  = memValid;
  assign mem_bus.result = '{isVector: memIsVector, address: memAddress,
                            scalarData: memScalarData, vectorData: memVectorData};
  assign memReady       = mem_bus.ready;

  logic [1:0] full, grant;
  wb_result_t held [2];
  wb_result_t issue;

  wb_holder u_ex_holder (.clk(clock), .rst_n(reset), .src(ex_bus),
                         .clear(grant[SRC_EX]), .full(full[SRC_EX]), .entry(held[SRC_EX]));
  wb_holder u_mem_holder (.clk(clock), .rst_n(reset), .src(mem_bus),
                          .clear(grant[SRC_MEM]), .full(full[SRC_MEM]), .entry(held[SRC_MEM]));

  // age_q = 1 means the mem holder is the older of two full holders
  logic age_q, age_d;

  always_comb begin
    grant = '0;
    if (full[SRC_MEM] && (!full[SRC_EX] || age_q)) grant[SRC_MEM] = 1'b1;
    else if (full[SRC_EX])                         grant[SRC_EX]  = 1'b1;
    issue = grant[SRC_MEM] ? held[SRC_MEM] : held[SRC_EX];
  end

  // A holder kept full across the edge predates anything loaded alongside it
  always_comb begin
    age_d = age_q;
    if (full[SRC_EX] && !grant[SRC_EX])                    age_d = 1'b0;
    else if ((full[SRC_MEM] && !grant[SRC_MEM]) ||
             (exValid && exReady && memValid && memReady)) age_d = 1'b1;
  end

  logic                              we_s_q, we_s_d, we_v_q, we_v_d;
  logic [ADDRESS_WIDTH-1:0]          addr_q, addr_d;
  logic [DATA_WIDTH-1:0]             sdata_q, sdata_d;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vdata_q, vdata_d;

  always_comb begin
    we_s_d  = 1'b0;
    we_v_d  = 1'b0;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    vdata_d = vdata_q;
    if (|grant) begin
      addr_d = issue.address;
      if (issue.isVector) begin
        we_v_d  = 1'b1;
        vdata_d = issue.vectorData;
      end else begin
        we_s_d  = 1'b1;
        sdata_d = issue.scalarData;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age_q   <= 1'b0;
      we_s_q  <= 1'b0;
      we_v_q  <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      vdata_q <= '0;
    end else begin
      age_q   <= age_d;
      we_s_q  <= we_s_d;
      we_v_q  <= we_v_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      vdata_q <= vdata_d;
    end
  end

  assign writeEnableScalar = we_s_q;
  assign writeEnableVector = we_v_q;
  assign writeAddress      = addr_q;
  assign writeScalarData   = sdata_q;
  assign writeVectorData   = vdata_q;

  assign pendingScalar =
      wb_onehot(full[SRC_EX]  && !held[SRC_EX].isVector,  held[SRC_EX].address) |
      wb_onehot(full[SRC_MEM] && !held[SRC_MEM].isVector, held[SRC_MEM].address);
  assign pendingVector =
      wb_onehot(full[SRC_EX]  && held[SRC_EX].isVector,   held[SRC_EX].address) |
      wb_onehot(full[SRC_MEM] && held[SRC_MEM].isVector,  held[SRC_MEM].address);

`ifdef WB_PERF_COUNTERS_EN
  logic [31:0] swc_q, swc_d, vwc_q, vwc_d, stall_q, stall_d;

  always_comb begin
    swc_d   = swc_q;
    vwc_d   = vwc_q;
    stall_d = stall_q;
    if (we_s_d && (swc_q != '1)) swc_d = swc_q + 32'd1;
    if (we_v_d && (vwc_q != '1)) vwc_d = vwc_q + 32'd1;
    if (((exValid && !exReady) || (memValid && !memReady)) && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      swc_q   <= '0;
      vwc_q   <= '0;
      stall_q <= '0;
    end else begin
      swc_q   <= swc_d;
      vwc_q   <= vwc_d;
      stall_q <= stall_d;
    end
  end

  assign scalarWriteCount = swc_q;
  assign vectorWriteCount = vwc_q;
  assign stallCount       = stall_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, single issue, contention, ordering,
// back-to-back traffic and mid-operation reset, checked with immediate assertions.
module tb_writeback_unit;
  import wb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  writeback_unit_if ex_if ();
  writeback_unit_if mem_if ();

  logic        writeEnableScalar, writeEnableVector;
  logic [3:0]  writeAddress;
  logic [7:0]  writeScalarData;
  logic [47:0] writeVectorData;
  logic [15:0] pendingScalar, pendingVector;
`ifdef WB_PERF_COUNTERS_EN
  logic [31:0] scalarWriteCount, vectorWriteCount, stallCount;
`endif

  writeback_unit dut (
    .clock(clock), .reset(reset),
    .exValid(ex_if.valid), .exReady(ex_if.ready), .exIsVector(ex_if.result.isVector),
    .exAddress(ex_if.result.address), .exScalarData(ex_if.result.scalarData),
    .exVectorData(ex_if.result.vectorData),
    .memValid(mem_if.valid), .memReady(mem_if.ready), .memIsVector(mem_if.result.isVector),
    .memAddress(mem_if.result.address), .memScalarData(mem_if.result.scalarData),
    .memVectorData(mem_if.result.vectorData),
    .writeEnableScalar(writeEnableScalar), .writeEnableVector(writeEnableVector),
    .writeAddress(writeAddress), .writeScalarData(writeScalarData),
    .writeVectorData(writeVectorData),
    .pendingScalar(pendingScalar), .pendingVector(pendingVector)
`ifdef WB_PERF_COUNTERS_EN
    , .scalarWriteCount(scalarWriteCount), .vectorWriteCount(vectorWriteCount),
    .stallCount(stallCount)
`endif
  );

  // Scalar register file as Decode would write it, on the falling edge
  logic [7:0] rf_s [16];
  always @(negedge clock) if (writeEnableScalar) rf_s[writeAddress] <= writeScalarData;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic isv, input logic [3:0] a,
                          input logic [7:0] s, input logic [47:0] vd);
    ex_if.valid = v;
    ex_if.result.isVector = isv;
    ex_if.result.address = a;
    ex_if.result.scalarData = s;
    ex_if.result.vectorData = vd;
  endtask

  task automatic drive_mem(input logic v, input logic isv, input logic [3:0] a,
                           input logic [7:0] s, input logic [47:0] vd);
    mem_if.valid = v;
    mem_if.result.isVector = isv;
    mem_if.result.address = a;
    mem_if.result.scalarData = s;
    mem_if.result.vectorData = vd;
  endtask

  initial begin
    reset = 1'b0;
    drive_ex(1'b0, 1'b0, 4'd0, 8'h00, '0);
    drive_mem(1'b0, 1'b0, 4'd0, 8'h00, '0);
    #2;
    chk("rst_we_s", writeEnableScalar, 0);
    chk("rst_we_v", writeEnableVector, 0);
    chk("rst_addr", writeAddress, 0);
    chk("rst_sdata", writeScalarData, 0);
    chk("rst_vdata", writeVectorData, 0);
    chk("rst_pend_s", pendingScalar, 0);
    chk("rst_pend_v", pendingVector, 0);
    chk("rst_ex_ready", ex_if.ready, 1);
    chk("rst_mem_ready", mem_if.ready, 1);
    #10 reset = 1'b1;

    // single scalar result: one edge to issue
    drive_ex(1'b1, 1'b0, 4'd3, 8'h5A, '0);
    chk("t1_ex_ready", ex_if.ready, 1);
    tick();
    drive_ex(1'b0, 1'b0, 4'd0, 8'h00, '0);
    chk("t1_pend_s", pendingScalar, 16'h0008);
    chk("t1_we_s_early", writeEnableScalar, 0);
    tick();
    chk("t1_we_s", writeEnableScalar, 1);
    chk("t1_we_v", writeEnableVector, 0);
    chk("t1_addr", writeAddress, 3);
    chk("t1_sdata", writeScalarData, 8'h5A);
    chk("t1_pend_s_clr", pendingScalar, 0);
    tick();
    chk("t1_we_s_off", writeEnableScalar, 0);
    chk("t1_addr_hold", writeAddress, 3);

    // simultaneous fill: mem (vector r2) older than ex (scalar r2)
    drive_ex(1'b1, 1'b0, 4'd2, 8'h22, '0);
    drive_mem(1'b1, 1'b1, 4'd2, 8'h00, 48'h1111_1111_1111);
    tick();
    drive_ex(1'b0, 1'b0, 4'd0, 8'h00, '0);
    drive_mem(1'b0, 1'b0, 4'd0, 8'h00, '0);
    chk("t2_pend_s", pendingScalar, 16'h0004);
    chk("t2_pend_v", pendingVector, 16'h0004);
    chk("t2_ex_ready", ex_if.ready, 0);
    chk("t2_mem_ready", mem_if.ready, 1);
    tick();
    chk("t2_we_v", writeEnableVector, 1);
    chk("t2_we_s0", writeEnableScalar, 0);
    chk("t2_addr_v", writeAddress, 2);
    chk("t2_vdata", writeVectorData, 48'h1111_1111_1111);
    chk("t2_sdata_kept", writeScalarData, 8'h5A);
    chk("t2_pend_v_clr", pendingVector, 0);
    chk("t2_ex_ready1", ex_if.ready, 1);
    tick();
    chk("t2_we_s", writeEnableScalar, 1);
    chk("t2_we_v0", writeEnableVector, 0);
    chk("t2_addr_s", writeAddress, 2);
    chk("t2_sdata", writeScalarData, 8'h22);
    chk("t2_vdata_kept", writeVectorData, 48'h1111_1111_1111);
    chk("t2_pend_s_clr", pendingScalar, 0);

    // same destination r7 from both sources: mem value lands first
    drive_mem(1'b1, 1'b0, 4'd7, 8'hAA, '0);
    drive_ex(1'b1, 1'b0, 4'd7, 8'hBB, '0);
    tick();
    drive_ex(1'b0, 1'b0, 4'd0, 8'h00, '0);
    drive_mem(1'b0, 1'b0, 4'd0, 8'h00, '0);
    chk("t3_pend_s", pendingScalar, 16'h0080);
    tick();
    chk("t3_first", writeScalarData, 8'hAA);
    chk("t3_first_we", writeEnableScalar, 1);
    chk("t3_first_addr", writeAddress, 7);
    tick();
    chk("t3_second", writeScalarData, 8'hBB);
    chk("t3_second_we", writeEnableScalar, 1);
    tick();
    chk("t3_rf7", rf_s[7], 8'hBB);
    chk("t3_idle", writeEnableScalar, 0);

    // ex already full, mem fills on the next edge: ex issues first
    drive_ex(1'b1, 1'b0, 4'd5, 8'h55, '0);
    tick();
    drive_ex(1'b0, 1'b0, 4'd0, 8'h00, '0);
    drive_mem(1'b1, 1'b0, 4'd6, 8'h66, '0);
    chk("t4_mem_ready", mem_if.ready, 1);
    tick();
    drive_mem(1'b0, 1'b0, 4'd0, 8'h00, '0);
    chk("t4_ex_first_addr", writeAddress, 5);
    chk("t4_ex_first_data", writeScalarData, 8'h55);
    chk("t4_pend_s", pendingScalar, 16'h0040);
    tick();
    chk("t4_mem_addr", writeAddress, 6);
    chk("t4_mem_data", writeScalarData, 8'h66);
    chk("t4_mem_we", writeEnableScalar, 1);

    // back-to-back ex traffic, one write per cycle
    for (int i = 0; i < 16; i++) begin
      drive_ex(1'b1, 1'b0, 4'(i), 8'(8'h30 + i), '0);
      chk("t5_ex_ready", ex_if.ready, 1);
      tick();
      if (i > 0) begin
        chk("t5_we_s", writeEnableScalar, 1);
        chk("t5_addr", writeAddress, 64'(i - 1));
        chk("t5_sdata", writeScalarData, 64'(8'h30 + i - 1));
      end
    end
    drive_ex(1'b0, 1'b0, 4'd0, 8'h00, '0);
    tick();
    chk("t5_last_addr", writeAddress, 15);
    chk("t5_last_data", writeScalarData, 8'h3F);
    tick();
    chk("t5_drained", writeEnableScalar, 0);
    for (int r = 0; r < 16; r++) chk("t5_rf", rf_s[r], 64'(8'h30 + r));

    // reset while a write is on the port and ex is still held
    drive_ex(1'b1, 1'b0, 4'd9, 8'h99, '0);
    drive_mem(1'b1, 1'b1, 4'd10, 8'h00, 48'hCCCC_CCCC_CCCC);
    tick();
    drive_ex(1'b0, 1'b0, 4'd0, 8'h00, '0);
    drive_mem(1'b0, 1'b0, 4'd0, 8'h00, '0);
    tick();
    chk("t6_pre_we_v", writeEnableVector, 1);
    chk("t6_pre_pend_s", pendingScalar, 16'h0200);
    #2 reset = 1'b0;
    #1;
    chk("t6_we_s", writeEnableScalar, 0);
    chk("t6_we_v", writeEnableVector, 0);
    chk("t6_pend_s", pendingScalar, 0);
    chk("t6_pend_v", pendingVector, 0);
    chk("t6_ex_ready", ex_if.ready, 1);
    chk("t6_mem_ready", mem_if.ready, 1);
    chk("t6_addr", writeAddress, 0);
    chk("t6_vdata", writeVectorData, 0);
`ifdef WB_PERF_COUNTERS_EN
    chk("t6_swc", scalarWriteCount, 0);
    chk("t6_vwc", vectorWriteCount, 0);
    chk("t6_stall", stallCount, 0);
`endif
    #2 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_post_we_s", writeEnableScalar, 0);
      chk("t6_post_we_v", writeEnableVector, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Register-file write side of the pipeline. Collects results from the execute path and the memory path, buffers one result per source, and serialises them onto the single shared scalar/vector write port.
- Drives writeEnableScalar, writeEnableVector, writeAddress, writeScalarData and writeVectorData into Decode, whose register files write on the falling clock edge.
- Exports pending-destination bitmaps so hazard logic can stall reads of registers that have not yet been written.

Parameters:
- DATA_WIDTH, 8, width of one scalar lane
- VECTOR_SIZE, 6, lanes per vector register
- REGNUM, 16, registers per file (scalar and vector)
- ADDRESS_WIDTH, 4, register address width, clog2(REGNUM)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- exValid  in  1  execute result present
- exReady  out  1  execute result accepted when exValid && exReady
- exIsVector  in  1  1 = vector destination, 0 = scalar destination
- exAddress  in  ADDRESS_WIDTH  destination register
- exScalarData  in  DATA_WIDTH  scalar result
- exVectorData  in  VECTOR_SIZE*DATA_WIDTH  vector result, packed [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]
- memValid, memReady, memIsVector, memAddress, memScalarData, memVectorData  same widths and meanings as the ex* ports, for the memory path
- writeEnableScalar  out  1  scalar register-file write strobe
- writeEnableVector  out  1  vector register-file write strobe
- writeAddress  out  ADDRESS_WIDTH  write address
- writeScalarData  out  DATA_WIDTH  scalar write data
- writeVectorData  out  VECTOR_SIZE*DATA_WIDTH  vector write data
- pendingScalar  out  REGNUM  bit r = scalar register r is held in a buffer and not yet issued
- pendingVector  out  REGNUM  bit r = vector register r is held in a buffer and not yet issued

Behaviour:
- Reset (reset=0, asynchronous): both holders empty, age bit = 0, all write outputs 0 (strobes, address, data). pendingScalar and pendingVector read 0 and ready outputs read 1 as soon as reset asserts. Reset in the middle of operation discards all held results.
- Holders: one entry per source storing {isVector, address, data}.
  - srcReady = holder empty OR holder is granted this cycle. Full throughput is one result per source per cycle when not contended.
  - Accept on valid && ready at the rising edge.
- Age tracking: the age bit records which full holder was filled first.
  - If both holders fill on the same edge, mem is older, because it is the later pipeline stage.
  - If one holder fills while the other is already full, the one already full is older.
- Issue, at most one per cycle:
  - At each rising edge, if any holder is full, grant the oldest (the only one, if only one is full).
  - The granted entry is registered into the write outputs. Exactly one strobe (scalar or vector per isVector) is 1 for that cycle; the holder is then emptied.
  - With no grant, both strobes are 0 on the next cycle. Address and data hold their last values.
- Latency:
  - Accepted at edge N → write outputs valid during cycle N+1..N+2 (registered at edge N+1) → register file writes on the falling edge in that cycle.
  - An accept and an empty holder give minimum latency 1 edge to issue.
- Contention: with both holders full, one issues per cycle. The non-granted source's ready is 0 and its holder keeps its contents.
- Same-destination ordering: results to the same file and address always issue in age order, so the last write reflects program order.
- Pending bitmaps are combinational OR-decodes of the full holders' {isVector, address}. An issued entry's bit clears at the same edge its strobe registers.
- Vector writes carry all VECTOR_SIZE lanes; there is no partial-lane masking. Scalar results never touch vector outputs and vice versa.

Optional Feature:
- WB_PERF_COUNTERS_EN
- Defined: adds outputs scalarWriteCount and vectorWriteCount (32-bit, incremented per issued strobe) and stallCount (32-bit, incremented each cycle either source has valid && !ready).
  - All three are cleared by reset and saturate at all-ones.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - typedef wb_result_t {isVector, address, scalarData, vectorData}
  - localparam SRC_EX=0 and SRC_MEM=1
- Natural sub-module: wb_holder, a one-entry buffer with valid/ready, load and clear, instantiated twice.
- Arbitration, age bit, output registers and bitmaps live in the top module.

Test Plan:
- Reset, then exValid=1, exIsVector=0, exAddress=3, exScalarData=8'h5A → exactly one cycle later writeEnableScalar=1, writeAddress=3, writeScalarData=8'h5A; pendingScalar[3]=1 only in the cycle between accept and issue.
- memValid and exValid on the same edge, mem→vector r2 = {6{8'h11}}, ex→scalar r2=8'h22 → vector write issues first, scalar write next cycle; exReady=0 for one cycle.
- Both sources target scalar r7 on the same edge (mem=8'hAA, ex=8'hBB) → writes issue AA then BB; final register value BB.
- ex holder full, mem fills on the next edge → ex issues first despite mem priority on simultaneous fills.
- Continuous back-to-back ex-only traffic to r0..r15 → one scalar write per cycle, exReady always 1, no drops.
- Assert reset with both holders full → strobes, pending bitmaps and holders go to 0 immediately; no write occurs after release. With WB_PERF_COUNTERS_EN, counters read 0.
